time_display_scanner: RTL

- Downstream consumer of the timer/clock block's time fields: hours (5b), minutes (6b), seconds (6b), centiseconds (7b), plus the ring flag.
- Snapshots the fields and converts them to 8 BCD digits (HH MM SS cc) with a sequential double-dabble engine.
- Drives a multiplexed 8-digit common-anode seven-segment display, with separator dots and a blink while the ring flag is high.

---
 rtl/time_display_scanner_if.sv | 22 ++
 rtl/time_display_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/time_display_scanner_if.sv
// rtl/time_display_scanner_if.sv - time fields in, multiplexed seven-segment display out
interface time_display_scanner_if;
  logic [4:0] timeInHoursDisplay;
  logic [5:0] timeInMinutesDisplay;
  logic [5:0] timeInSeconds;
  logic [6:0] millisecondsDisplay;
  logic       ringSound;
  logic [6:0] segments;
  logic       decimalPoint;
  logic [7:0] digitSelect;
  logic       frameValid;

  modport master (
    output timeInHoursDisplay, timeInMinutesDisplay, timeInSeconds, millisecondsDisplay, ringSound,
    input  segments, decimalPoint, digitSelect, frameValid
  );

  modport slave (
    input  timeInHoursDisplay, timeInMinutesDisplay, timeInSeconds, millisecondsDisplay, ringSound,
    output segments, decimalPoint, digitSelect, frameValid
  );
endinterface

// File: rtl/time_display_scanner.sv
// rtl/time_display_scanner.sv - snapshot, double-dabble to 8 BCD digits, scanned 7-seg drive
// Optional macro LEADING_ZERO_BLANK_EN blanks the hours-tens digit when it is zero.
module time_display_scanner #(
  parameter int SCAN_DIV       = 1,
  parameter int BLINK_DIV      = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                  clockSignal,
  input logic                  startOrStop,
  time_display_scanner_if.slave disp
);
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CS = 0, SC = 1, MN = 2, HR = 3;

  typedef enum logic [1:0] {IDLE, LOAD, CONVERT, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [4:0]          hr_q, hr_d;
  logic [5:0]          mn_q, mn_d;
  logic [5:0]          sc_q, sc_d;
  logic [6:0]          cs_q, cs_d;
  // Each field: {tens, ones, 7-bit binary} shifted left once per CONVERT cycle.
  logic [3:0][14:0]    sh_q, sh_d;
  logic [7:0][3:0]     buf_q, buf_d;
  logic                fv_q, fv_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [7:0]          dsel_q, dsel_d;
  logic [6:0]          cs_clamp;
  logic [3:0]          digit;
  logic [6:0]          seg_hi;
  logic                dp_hi;
  logic [7:0]          dsel_hi;

  function automatic logic [14:0] dabble(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 7'h3F;
      4'd1:    seg_lut = 7'h06;
      4'd2:    seg_lut = 7'h5B;
      4'd3:    seg_lut = 7'h4F;
      4'd4:    seg_lut = 7'h66;
      4'd5:    seg_lut = 7'h6D;
      4'd6:    seg_lut = 7'h7D;
      4'd7:    seg_lut = 7'h07;
      4'd8:    seg_lut = 7'h7F;
      4'd9:    seg_lut = 7'h6F;
      default: seg_lut = 7'h00;
    endcase
  endfunction

  assign cs_clamp = (disp.millisecondsDisplay > 7'd99) ? 7'd99 : disp.millisecondsDisplay;

  // The snapshot keeps the raw centiseconds so an out-of-range input does not retrigger forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hr_d    = hr_q;
    mn_d    = mn_q;
    sc_d    = sc_q;
    cs_d    = cs_q;
    sh_d    = sh_q;
    buf_d   = buf_q;
    fv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if ({disp.timeInHoursDisplay, disp.timeInMinutesDisplay, disp.timeInSeconds,
             disp.millisecondsDisplay} != {hr_q, mn_q, sc_q, cs_q})
          state_d = LOAD;
      end
      LOAD: begin
        hr_d     = disp.timeInHoursDisplay;
        mn_d     = disp.timeInMinutesDisplay;
        sc_d     = disp.timeInSeconds;
        cs_d     = disp.millisecondsDisplay;
        sh_d[HR] = 15'(disp.timeInHoursDisplay);
        sh_d[MN] = 15'(disp.timeInMinutesDisplay);
        sh_d[SC] = 15'(disp.timeInSeconds);
        sh_d[CS] = 15'(cs_clamp);
        cnt_d    = 3'd0;
        state_d  = CONVERT;
      end
      CONVERT: begin
        for (int i = 0; i < 4; i++) sh_d[i] = dabble(sh_q[i]);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          state_d = COMMIT;
          fv_d    = 1'b1;
        end
      end
      COMMIT: begin
        buf_d   = {sh_q[HR][14:7], sh_q[MN][14:7], sh_q[SC][14:7], sh_q[CS][14:7]};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    if (disp.ringSound) begin
      blink_phase_d = blink_phase_q;
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end
    end

    digit   = buf_q[idx_q];
    seg_hi  = seg_lut(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == 3'd7 && digit == 4'd0) seg_hi = 7'h00;
`endif
    dp_hi   = (idx_q == 3'd2) || (idx_q == 3'd4) || (idx_q == 3'd6);
    dsel_hi = 8'b1 << idx_q;
    // Live ringSound gate lets a dropped alarm unblank on the very next edge.
    if (disp.ringSound && blink_phase_q) begin
      seg_hi  = 7'h00;
      dp_hi   = 1'b0;
      dsel_hi = 8'h00;
    end
    seg_d  = seg_hi ^ {7{SEG_ACTIVE_LOW}};
    dp_d   = dp_hi ^ SEG_ACTIVE_LOW;
    dsel_d = dsel_hi ^ {8{SEG_ACTIVE_LOW}};
  end

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hr_q          <= '0;
      mn_q          <= '0;
      sc_q          <= '0;
      cs_q          <= '0;
      sh_q          <= '0;
      buf_q         <= '0;
      fv_q          <= 1'b0;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= {7{SEG_ACTIVE_LOW}};
      dp_q          <= SEG_ACTIVE_LOW;
      dsel_q        <= {8{SEG_ACTIVE_LOW}};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hr_q          <= hr_d;
      mn_q          <= mn_d;
      sc_q          <= sc_d;
      cs_q          <= cs_d;
      sh_q          <= sh_d;
      buf_q         <= buf_d;
      fv_q          <= fv_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dsel_q        <= dsel_d;
    end
  end

  assign disp.segments     = seg_q;
  assign disp.decimalPoint = dp_q;
  assign disp.digitSelect  = dsel_q;
  assign disp.frameValid   = fv_q;
endmodule
